// File: rtl/aes_cbc_ctrl_pkg.sv
// Shared types and constants for the AES stream front-end: core command/response
// records, func codes, controller state encoding and latched configuration.
package aes_cbc_ctrl_pkg;

  localparam int unsigned AES_NB     = 4;
  localparam int unsigned AES_NK     = 4;
  localparam int unsigned AES_DATA_W = 32 * AES_NB;
  localparam int unsigned AES_KEY_W  = 32 * AES_NK;

  localparam logic [1:0] AES_FUNC_KEY = 2'd1;
  localparam logic [1:0] AES_FUNC_ENC = 2'd2;
  localparam logic [1:0] AES_FUNC_DEC = 2'd3;

  typedef struct packed {
    logic [AES_KEY_W-1:0]  key;
    logic [AES_DATA_W-1:0] data;
    logic [1:0]            func;
    logic                  enable;
  } aes_in_type;

  typedef struct packed {
    logic                  ready;
    logic [AES_DATA_W-1:0] result;
  } aes_out_type;

  typedef enum logic [2:0] {
    IDLE,
    KEY,
    GAP,
    ISSUE,
    WAIT,
    OUT
  } cbc_state_t;

  typedef struct packed {
    logic [AES_KEY_W-1:0]  key;
    logic [AES_DATA_W-1:0] iv;
    logic                  dec;
    logic                  cbc;
  } aes_cbc_cfg_type;

  // Chaining XOR: applied to the core input (CBC encrypt) or output (CBC decrypt).
  function automatic logic [AES_DATA_W-1:0] chain_mix(input logic en,
                                                      input logic [AES_DATA_W-1:0] a,
                                                      input logic [AES_DATA_W-1:0] b);
    return en ? (a ^ b) : a;
  endfunction

endpackage

// File: rtl/aes_cbc_ctrl_if.sv
// Block stream bus: input (s_*) and output (m_*) valid/ready channels.
interface aes_cbc_ctrl_if #(
  parameter int unsigned DATA_W = 128
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data
  );
endinterface

// File: rtl/aes_cbc_ctrl.sv
// Stream front-end for the aes core: key expansion, ECB/CBC chaining and a
// one-entry output buffer; the only driver of aes_in.
module aes_cbc_ctrl
  import aes_cbc_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W  = AES_DATA_W,
  parameter int unsigned KEY_W   = AES_KEY_W,
  parameter int unsigned KEY_GAP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_load,
  input  logic [KEY_W-1:0]  cfg_key,
  input  logic [DATA_W-1:0] cfg_iv,
  input  logic              cfg_dec,
  input  logic              cfg_cbc,
  output logic              cfg_err,
  aes_cbc_ctrl_if.slave     bus,
  output logic              busy,
  output aes_in_type        aes_in,
  input  aes_out_type       aes_out
);

  localparam int unsigned GAP_LAST = (KEY_GAP > 0) ? KEY_GAP - 1 : 0;
  localparam int unsigned GAP_W    = (GAP_LAST > 0) ? $clog2(GAP_LAST + 1) : 1;

  cbc_state_t        state;
  aes_cbc_cfg_type   cfg;
  logic              keyed;
  logic [DATA_W-1:0] blk;
  logic [DATA_W-1:0] chain;
  logic [GAP_W-1:0]  gap_cnt;
  logic              m_valid_q;
  logic [DATA_W-1:0] m_data_q;
  logic              s_hs;

  // A cfg_load in the same cycle wins, so s_ready drops to keep the block from being lost.
  assign bus.s_ready = (state == IDLE) & keyed & ~m_valid_q & ~cfg_load;
  assign s_hs        = bus.s_valid & bus.s_ready;
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign busy        = (state != IDLE) | m_valid_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cfg       <= '0;
      keyed     <= 1'b0;
      blk       <= '0;
      chain     <= '0;
      gap_cnt   <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_err <= cfg_load & (state != IDLE);
      unique case (state)
        IDLE: begin
          if (cfg_load) begin
            cfg   <= '{key: cfg_key, iv: cfg_iv, dec: cfg_dec, cbc: cfg_cbc};
            state <= KEY;
          end else if (s_hs) begin
            blk   <= bus.s_data;
            state <= ISSUE;
          end
        end
        KEY: begin
          // Chain is re-seeded here from the IV latched on the previous edge.
          chain   <= cfg.iv;
          keyed   <= 1'b1;
          gap_cnt <= '0;
          state   <= GAP;
        end
        GAP: begin
          if (gap_cnt == GAP_W'(GAP_LAST)) state <= IDLE;
          else                             gap_cnt <= gap_cnt + GAP_W'(1);
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (aes_out.ready) begin
            m_data_q  <= chain_mix(cfg.cbc & cfg.dec, aes_out.result, chain);
            m_valid_q <= 1'b1;
            if (cfg.cbc) chain <= cfg.dec ? blk : aes_out.result;
            state     <= OUT;
          end
        end
        OUT: begin
          if (bus.m_ready) begin
            m_valid_q <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    aes_in = '0;
    unique case (state)
      KEY: begin
        aes_in.enable = 1'b1;
        aes_in.func   = AES_FUNC_KEY;
        aes_in.key    = cfg.key;
      end
      ISSUE: begin
        aes_in.enable = 1'b1;
        aes_in.func   = cfg.dec ? AES_FUNC_DEC : AES_FUNC_ENC;
        aes_in.data   = chain_mix(cfg.cbc & ~cfg.dec, blk, chain);
      end
      default: aes_in = '0;
    endcase
  end

endmodule

// File: tb/tb_aes_cbc_ctrl.sv
// Bench for aes_cbc_ctrl with a behavioural AES-128 core stand-in and reference model.
module tb_aes_cbc_ctrl;

  logic         clk;
  logic         rst;
  logic         cfg_load;
  logic [127:0] cfg_key;
  logic [127:0] cfg_iv;
  logic         cfg_dec;
  logic         cfg_cbc;
  logic         cfg_err;
  logic         busy;
  aes_cbc_ctrl_pkg::aes_in_type  aes_in;
  aes_cbc_ctrl_pkg::aes_out_type aes_out;

  aes_cbc_ctrl_if #(.DATA_W(128)) bus ();

  aes_cbc_ctrl #(.DATA_W(128), .KEY_W(128), .KEY_GAP(1)) dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_key(cfg_key), .cfg_iv(cfg_iv),
    .cfg_dec(cfg_dec), .cfg_cbc(cfg_cbc), .cfg_err(cfg_err), .bus(bus), .busy(busy),
    .aes_in(aes_in), .aes_out(aes_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // ---------------- behavioural AES-128 ----------------
  logic [7:0] sbox [256];
  logic [7:0] isbox[256];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, r, s;
    for (int a = 0; a < 256; a++) begin
      inv = '0;
      if (a != 0)
        for (int b = 1; b < 256; b++)
          if (gm(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      r = inv; s = inv;
      for (int k = 0; k < 4; k++) begin
        r = {r[6:0], r[7]};
        s ^= r;
      end
      s ^= 8'h63;
      sbox[a]  = s;
      isbox[s] = 8'(a);
    end
  endtask

  function automatic logic [127:0] sub_b(input logic [127:0] x, input bit inv);
    logic [127:0] y;
    y = '0;
    for (int i = 0; i < 16; i++)
      y[8*i +: 8] = inv ? isbox[x[8*i +: 8]] : sbox[x[8*i +: 8]];
    return y;
  endfunction

  // byte k = row + 4*col, byte 0 is the MSB
  function automatic logic [127:0] shift_r(input logic [127:0] x, input bit inv);
    logic [127:0] y;
    int d, s;
    y = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        d = r + 4*c;
        s = r + 4*((c + r) % 4);
        if (!inv) y[127-8*d -: 8] = x[127-8*s -: 8];
        else      y[127-8*s -: 8] = x[127-8*d -: 8];
      end
    return y;
  endfunction

  function automatic logic [127:0] mix_c(input logic [127:0] x, input bit inv);
    logic [7:0]   m[4];
    logic [7:0]   acc;
    logic [127:0] y;
    y = '0;
    if (inv) m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     m = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = '0;
        for (int j = 0; j < 4; j++)
          acc ^= gm(m[(j - r + 4) % 4], x[127-8*(j+4*c) -: 8]);
        y[127-8*(r+4*c) -: 8] = acc;
      end
    return y;
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] din, input bit dec);
    logic [31:0]  w[44];
    logic [127:0] rk[11];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [127:0] s;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    if (!dec) begin
      s = din ^ rk[0];
      for (int r = 1; r < 10; r++) s = mix_c(shift_r(sub_b(s, 0), 0), 0) ^ rk[r];
      s = shift_r(sub_b(s, 0), 0) ^ rk[10];
    end else begin
      s = din ^ rk[10];
      for (int r = 9; r >= 1; r--) s = mix_c(sub_b(shift_r(s, 1), 1) ^ rk[r], 1);
      s = sub_b(shift_r(s, 1), 1) ^ rk[0];
    end
    return s;
  endfunction

  // ---------------- core stand-in + command monitor ----------------
  logic [127:0] core_key = '0;
  logic [127:0] core_res = '0;
  int           core_cnt = 0;
  int           lat_cfg  = 0;
  int           en_cnt   = 0;
  int           proto_bad = 0;
  logic         prev_en  = 1'b0;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    prev_en <= aes_in.enable;
    if (core_cnt > 0) core_cnt <= core_cnt - 1;
    if (aes_in.enable) begin
      en_cnt <= en_cnt + 1;
      if (prev_en) proto_bad <= proto_bad + 1;
      if (aes_in.func == 2'd1) core_key <= aes_in.key;
      else begin
        core_res <= aes_ref(core_key, aes_in.data, aes_in.func == 2'd3);
        core_cnt <= (lat_cfg > 0) ? lat_cfg : int'($urandom_range(1, 4));
      end
    end else if (aes_in != '0) begin
      proto_bad <= proto_bad + 1;
    end
  end

  assign aes_out.ready  = (core_cnt == 1);
  assign aes_out.result = (core_cnt == 1) ? core_res : '0;

  // ---------------- stimulus helpers ----------------
  task automatic load_cfg(input logic [127:0] k, input logic [127:0] iv, input bit dec, input bit cbc);
    @(negedge clk);
    cfg_key = k; cfg_iv = iv; cfg_dec = dec; cfg_cbc = cbc; cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
    check("load_no_err", cfg_err, 0);
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    check("load_idle", busy, 0);
  endtask

  task automatic xfer(input logic [127:0] din, input int stall, output logic [127:0] dout, output bit ok);
    ok = 0; dout = '0;
    bus.s_valid = 1'b1; bus.s_data = din; bus.m_ready = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.s_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) begin bus.s_valid = 1'b0; return; end
    @(posedge clk); #1 bus.s_valid = 1'b0;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.m_valid) begin ok = 1; break; end
    end
    if (!ok) return;
    repeat (stall) @(negedge clk);
    dout = bus.m_data;
    bus.m_ready = 1'b1;
    @(posedge clk); #1 bus.m_ready = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    bit           load;
    logic [127:0] key;
    logic [127:0] iv;
    bit           dec;
    bit           cbc;
    logic [127:0] din;
    logic [127:0] dout;
  } vec_t;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] P2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] C1 = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] C2 = 128'h5086cb9b507219ee95db113a917678b2;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         vt[8];
    logic [127:0] got, exp, first, rkey, riv, rchain, p;
    bit           ok, rdec, rcbc;
    int           c0, e0, viol;

    vt[0] = '{1, K1, '0, 0, 0, P0, C0};
    vt[1] = '{1, K1, '0, 1, 0, C0, P0};
    vt[2] = '{1, K2, K1, 0, 1, P1, C1};
    vt[3] = '{0, K2, K1, 0, 1, P2, C2};
    vt[4] = '{1, K2, K1, 1, 1, C1, P1};
    vt[5] = '{0, K2, K1, 1, 1, C2, P2};
    vt[6] = '{1, K2, K1, 1, 1, C1, P1};
    vt[7] = '{0, K2, K1, 1, 1, C2, P2};

    rst = 1'b0; cfg_load = 1'b0; cfg_key = '0; cfg_iv = '0; cfg_dec = 1'b0; cfg_cbc = 1'b0;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b0;
    build_sbox();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready", bus.s_ready, 0);
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_m_data", bus.m_data, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_busy", busy, 0);
    check("rst_aes_in", aes_in, 0);
    @(posedge clk); #1 rst = 1'b1;

    // block offered before any key: never accepted
    @(negedge clk);
    bus.s_valid = 1'b1; bus.s_data = P0; viol = 0;
    repeat (12) begin @(negedge clk); if (bus.s_ready) viol++; end
    bus.s_valid = 1'b0;
    check("nokey_s_ready", viol, 0);
    check("nokey_enables", en_cnt, 0);

    for (int i = 0; i < 8; i++) begin
      if (vt[i].load) load_cfg(vt[i].key, vt[i].iv, vt[i].dec, vt[i].cbc);
      xfer(vt[i].din, i % 3, got, ok);
      check($sformatf("vec%0d_done", i), ok, 1);
      check($sformatf("vec%0d_data", i), got, vt[i].dout);
    end

    // backpressure and latency, fixed core latency 3
    lat_cfg = 3;
    load_cfg(K1, '0, 0, 0);
    e0 = en_cnt; c0 = 0; ok = 0;
    bus.s_valid = 1'b1; bus.s_data = P0;
    for (int i = 0; i < 50 && !bus.s_ready; i++) @(negedge clk);
    @(posedge clk); #1 c0 = cyc; bus.s_valid = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.m_valid) begin ok = 1; break; end
    end
    check("bp_valid", ok, 1);
    check("bp_latency", cyc - c0, 4);
    first = bus.m_data; viol = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.m_data !== first || bus.s_ready !== 1'b0 || bus.m_valid !== 1'b1 || busy !== 1'b1) viol++;
    end
    check("bp_stable", viol, 0);
    check("bp_data", first, C0);
    check("bp_one_enable", en_cnt - e0, 1);
    bus.m_ready = 1'b1;
    @(posedge clk); #1 bus.m_ready = 1'b0;
    @(negedge clk);
    check("bp_drain_valid", bus.m_valid, 0);
    check("bp_drain_busy", busy, 0);

    // cfg_load while waiting on the core is rejected
    lat_cfg = 6; e0 = en_cnt;
    bus.s_valid = 1'b1; bus.s_data = P0;
    for (int i = 0; i < 50 && !bus.s_ready; i++) @(negedge clk);
    @(posedge clk); #1 bus.s_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    cfg_key = K2; cfg_iv = '1; cfg_dec = 1'b1; cfg_cbc = 1'b1; cfg_load = 1'b1;
    @(negedge clk); cfg_load = 1'b0;
    check("werr_pulse", cfg_err, 1);
    @(negedge clk);
    check("werr_clear", cfg_err, 0);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      if (bus.m_valid) begin ok = 1; break; end
      @(negedge clk);
    end
    check("werr_valid", ok, 1);
    check("werr_data", bus.m_data, C0);
    bus.m_ready = 1'b1;
    @(posedge clk); #1 bus.m_ready = 1'b0;
    @(negedge clk);
    xfer(P0, 0, got, ok);
    check("werr_next", got, C0);
    check("werr_enables", en_cnt - e0, 2);

    // reset while the core is busy; its late ready must be ignored
    bus.s_valid = 1'b1; bus.s_data = P0;
    for (int i = 0; i < 50 && !bus.s_ready; i++) @(negedge clk);
    @(posedge clk); #1 bus.s_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check("wrst_s_ready", bus.s_ready, 0);
    check("wrst_m_valid", bus.m_valid, 0);
    check("wrst_m_data", bus.m_data, 0);
    check("wrst_busy", busy, 0);
    check("wrst_cfg_err", cfg_err, 0);
    check("wrst_aes_in", aes_in, 0);
    @(posedge clk); #1 rst = 1'b1;
    viol = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.m_valid || busy || bus.s_ready) viol++;
    end
    check("wrst_late_ready", viol, 0);

    // randomized traffic against the chaining reference
    lat_cfg = 0;
    rkey = '0; riv = '0; rdec = 0; rcbc = 0; rchain = '0;
    for (int n = 0; n < 40; n++) begin
      if (n % 6 == 0) begin
        rkey = {$urandom, $urandom, $urandom, $urandom};
        riv  = {$urandom, $urandom, $urandom, $urandom};
        rdec = 1'($urandom); rcbc = 1'($urandom);
        rchain = riv;
        load_cfg(rkey, riv, rdec, rcbc);
      end
      p = {$urandom, $urandom, $urandom, $urandom};
      if (rcbc && !rdec) begin
        exp = aes_ref(rkey, p ^ rchain, 0);
        rchain = exp;
      end else if (rcbc && rdec) begin
        exp = aes_ref(rkey, p, 1) ^ rchain;
        rchain = p;
      end else begin
        exp = aes_ref(rkey, p, rdec);
      end
      xfer(p, int'($urandom_range(0, 3)), got, ok);
      check($sformatf("rnd%0d_done", n), ok, 1);
      check($sformatf("rnd%0d_data", n), got, exp);
    end

    check("aes_in_protocol", proto_bad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
